// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the video RAM fetch/arbitration slice.
package vga_pkg;

   localparam int H_ACTIVE = 640;                 // visible pixels per line (multiple of 8)
   localparam int V_ACTIVE = 480;                 // visible lines per frame
   localparam int WPL      = H_ACTIVE / 8;        // framebuffer words per line
   localparam int FB_WORDS = WPL * V_ACTIVE;      // total framebuffer words

   // Port-owner sequencing: one boot fetch, then CPU grants interleaved with display slots.
   typedef enum logic [1:0] {
      INIT,
      IDLE,
      CPU_BUSY
   } state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Maps a (line, group) framebuffer coordinate to a word address. With advance_i set
// it returns the word that follows the coordinate in scan order, stepping to the next
// line after the last group and back to address 0 after the last line.
module fb_addr_gen #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int ADDR_W   = 16
) (
   input  logic [9:0]        line_i,
   input  logic [6:0]        group_i,
   input  logic              advance_i,
   output logic [ADDR_W-1:0] addr_o
);

   localparam int WPL_L = H_ACTIVE / 8;

   logic [9:0]        line_sel;
   logic [6:0]        group_sel;
   logic [ADDR_W-1:0] line_w;

   // Select the coordinate to address, then form line*80 + group with two shifts.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      line_sel  = line_i;
      group_sel = group_i;
      if (advance_i) begin
         if (group_i == 7'(WPL_L - 1)) begin
            group_sel = 7'd0;
            line_sel  = (line_i == 10'(V_ACTIVE - 1)) ? 10'd0 : line_i + 10'd1;
         end else begin
            group_sel = group_i + 7'd1;
         end
      end
      line_w = ADDR_W'(line_sel);
      addr_o = (line_w << 6) + (line_w << 4) + ADDR_W'(group_sel);
   end

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Shares the single-port framebuffer RAM between the display prefetch (fixed slot 1 of
// every 8-pixel group) and a req/ack CPU port, and shifts fetched words out as 1-bpp pixels.
module vram_fetch_arbiter #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              de,
   input  logic [9:0]        pixh,
   input  logic [9:0]        pixv,
   output logic              pix_out,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int WPL_L      = H_ACTIVE / 8;
   localparam int FB_WORDS_L = WPL_L * V_ACTIVE;

   vga_pkg::state_e   state_q;
   logic              ack_q;
   logic              busy_rd_q;
   logic              busy_oor_q;
   logic [7:0]        rdata_q;
   logic [7:0]        cur_word_q;
   logic [7:0]        next_word_q;
   logic              disp_pend_q;
   logic              pix_q;

   logic [2:0]        slot;
   logic [6:0]        group;
   logic              disp_claim;
   logic              cpu_in_range;
   logic              grant;
   logic [ADDR_W-1:0] fetch_addr;

   assign slot         = pixh[2:0];
   assign group        = pixh[9:3];
   assign disp_claim   = de && (slot == 3'd1);
   assign cpu_in_range = (32'(cpu_addr) < 32'(FB_WORDS_L));
   // A held request is only granted from IDLE, so the CPU_BUSY cycle can never re-serve it.
   assign grant        = (state_q == vga_pkg::IDLE) && cpu_req && !disp_claim;

   // Address of the word needed for the next group (next line / frame wrap included).
   fb_addr_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .ADDR_W   (ADDR_W)
   ) u_fb_addr_gen (
      .line_i    (pixv),
      .group_i   (group),
      .advance_i (1'b1),
      .addr_o    (fetch_addr)
   );

   // RAM port mux: display claim beats the boot fetch, which beats a CPU grant; quiet otherwise.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         if (disp_claim) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
         end else if (state_q == vga_pkg::INIT) begin
            mem_en = 1'b1;
         end else if (grant && cpu_in_range) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
      end
   end

   // CPU side FSM: boot fetch, grant in a free cycle, ack and capture read data one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= vga_pkg::INIT;
         ack_q      <= 1'b0;
         busy_rd_q  <= 1'b0;
         busy_oor_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         ack_q <= 1'b0;
         unique case (state_q)
            vga_pkg::INIT: begin
               state_q <= vga_pkg::IDLE;
            end
            vga_pkg::IDLE: begin
               if (grant) begin
                  state_q    <= vga_pkg::CPU_BUSY;
                  ack_q      <= 1'b1;
                  busy_rd_q  <= !cpu_we;
                  busy_oor_q <= !cpu_in_range;
               end
            end
            vga_pkg::CPU_BUSY: begin
               state_q <= vga_pkg::IDLE;
               if (busy_rd_q) begin
                  rdata_q <= busy_oor_q ? 8'h00 : mem_rdata;
               end
            end
            default: begin
               state_q <= vga_pkg::INIT;
            end
         endcase
      end
   end

   // Read data is presented during the ack cycle straight from the RAM, then held from rdata_q.
   always_comb begin
      cpu_rdata = rdata_q;
      if ((state_q == vga_pkg::CPU_BUSY) && busy_rd_q) begin
         cpu_rdata = busy_oor_q ? 8'h00 : mem_rdata;
      end
   end

   assign cpu_ack = ack_q;

   // Display path: land prefetched words in next_word, swap at slot 0, shift MSB-first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_pend_q <= 1'b0;
         next_word_q <= '0;
         cur_word_q  <= '0;
         pix_q       <= 1'b0;
      end else begin
         disp_pend_q <= disp_claim || (state_q == vga_pkg::INIT);
         if (disp_pend_q) begin
            next_word_q <= mem_rdata;
         end
         if (de) begin
            if (slot == 3'd0) begin
               cur_word_q <= next_word_q;
               pix_q      <= next_word_q[7];
            end else begin
               pix_q <= cur_word_q[3'd7 - slot];
            end
         end else begin
            pix_q <= 1'b0;
         end
      end
   end

   assign pix_out = pix_q;

endmodule

// File: doc/vram_fetch_arbiter.md
# vram_fetch_arbiter

Shares the single-port 8-bit video RAM between the display pixel fetch and CPU read/write accesses, and serialises fetched bytes into a 1-bpp pixel stream. It sits between the VGA timing generator (which supplies `de`, `pixh`, `pixv`) and the framebuffer RAM. Display fetches own a fixed slot in every 8-pixel group; the CPU gets every other free cycle through a req/ack handshake.

## Interface
- `H_ACTIVE`, 640, visible pixels per line; must be a multiple of 8.
- `V_ACTIVE`, 480, visible lines per frame.
- `ADDR_W`, 16, RAM/CPU address width.
- `clk  in  1`: pixel clock, 25.175 MHz.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `de  in  1`: display enable from the timing generator; high in the visible area.
- `pixh  in  10`: x-coordinate of the active pixel; valid when `de`.
- `pixv  in  10`: y-coordinate of the active pixel; valid when `de`.
- `pix_out  out  1`: pixel for the `pixh`/`pixv` presented on the previous cycle.
- `cpu_req  in  1`: CPU access request; held until `cpu_ack`.
- `cpu_we  in  1`: 1 = write, 0 = read.
- `cpu_addr  in  ADDR_W`: byte address.
- `cpu_wdata  in  8`: write data.
- `cpu_ack  out  1`: one-cycle completion pulse.
- `cpu_rdata  out  8`: read data; valid with `cpu_ack`, held until the next read ack.
- `mem_en  out  1`: RAM access strobe; combinational.
- `mem_we  out  1`: RAM write enable; combinational.
- `mem_addr  out  ADDR_W`: RAM address; combinational.
- `mem_wdata  out  8`: RAM write data; combinational.
- `mem_rdata  in  8`: RAM read data, valid the cycle after a read strobe.

## Operation
- **Framebuffer layout**
  - `WPL = H_ACTIVE/8` = 80 words per line; `FB_WORDS = WPL*V_ACTIVE` = 38400.
  - Address = `line*80 + group`, computed as `(line<<6)+(line<<4)+group`, 16-bit.
  - Bit 7 of each word is the leftmost pixel.
- **Group/slot**
  - Group `g = pixh[9:3]`; slot `s = pixh[2:0]`.
- **Display fetch claim**
  - The display owns the RAM port in any cycle with `de && s==1`.
  - For `g<79`: read address of (`pixv`, `g+1`).
  - For `g==79`: read address of (`pixv+1`, 0). If `pixv==V_ACTIVE-1`, wrap to address 0.
  - The read data is written into `next_word` on the following cycle (`disp_pend` flag).
- **Pixel path**, registered, active only when `de`:
  - If `s==0`: `cur_word<=next_word` and `pix_out<=next_word[7]`.
  - Otherwise: `pix_out<=cur_word[7-s]`.
  - When `de` is low: `pix_out<=0`.
- **FSM states**
  - `INIT`: entered at reset. Issues a read of address 0, then goes to `IDLE`; the returned data loads `next_word`.
  - `IDLE`: if `cpu_req` and there is no display claim this cycle → grant, go to `CPU_BUSY`.
  - `CPU_BUSY`: pulse `cpu_ack`; for reads, capture `cpu_rdata<=mem_rdata`. Always returns to `IDLE` and never grants in this cycle, so a held `cpu_req` is never double-served.
  - Maximum CPU throughput is one access per 2 cycles.
- **Grant cycle** drives `mem_en=1`, `mem_we=cpu_we`, `mem_addr=cpu_addr`, `mem_wdata=cpu_wdata`.
- **Display claim vs. CPU request**
  - A display claim always wins; the CPU request waits.
  - A display claim may coincide with `CPU_BUSY`, because the port is free in that cycle.
- **Out-of-range CPU address** (`cpu_addr >= FB_WORDS`)
  - Still granted and acked.
  - `mem_en` stays 0.
  - Reads return 0x00.
- **Idle port**: outside grant and claim cycles, all `mem_*` outputs are 0.

## Timing
- **Reset values**: `pix_out=0`, `cpu_ack=0`, `cpu_rdata=0`, `cur_word=next_word=0`, `disp_pend=0`, state `INIT`; `mem_*` = 0 while `rst_n` is low.
- **Pixel latency**: 1 cycle from `pixh`/`pixv` to `pix_out`.
- **Fetch lead**: a fetch is issued at slot 1 of group g, and its data lands at slot 2 — 6 cycles before use at slot 0 of g+1.
- **CPU latency**: request at cycle T with no display claim → `mem_en` at T, `cpu_ack` at T+1. If T is a display slot, the grant moves to T+1 and `cpu_ack` to T+2.
- **Reset mid-operation**: the in-flight CPU transaction is dropped without an ack; the display shows 0 until the `INIT` fetch completes.

## Structure
- **Package `vga_pkg`**: `H_ACTIVE`, `V_ACTIVE`, `WPL`, `FB_WORDS`, and the state enum `{INIT, IDLE, CPU_BUSY}`.
- **Sub-module `fb_addr_gen`**: combinational (line, group) → address, including the next-line/wrap rule; reusable by a future sprite/cursor block.

## Test plan
- **Reset and first line**: release reset with RAM[0]=0xA5, then drive line 0 → `pix_out` is 1,0,1,0,0,1,0,1 for pixh 0..7, each one cycle late.
- **Slot collision**: `cpu_req` write 0x3C to addr 100, asserted in a `de && s==1` cycle → `mem_en` carries the display address that cycle; CPU is granted next cycle and `cpu_ack` arrives 2 cycles after the request.
- **Back-to-back reads**: `cpu_req` held for reads of addr 5 then addr 6 in blanking → grants exactly 2 cycles apart, `cpu_rdata` matches RAM, no duplicate ack.
- **Line and frame wrap**: RAM[80]=0xFF, RAM[0]=0x81 → pixel 0 of line 1 is 1; after line 479, line 0 shows 0x81.
- **Out of range**: write to 38400 gives `cpu_ack` with `mem_en` never asserted; read from 40000 gives `cpu_rdata=0x00`.
- **Reset mid-operation**: assert `rst_n` low during `CPU_BUSY` → no `cpu_ack`, all outputs at reset values asynchronously.
